ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have parameter MUL_ITER, 32: number of shift-add iterations for MULT.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_EX_valid  input  1  an instruction from decode is present.
REQ-005 SHALL have ports i_EX_regWe, i_EX_dMemWe  input  1 each  decode control bits for register write and data-memory write.
REQ-006 SHALL have port i_EX_WRA  input  5  destination register address.
REQ-007 SHALL have port i_EX_aluOp  input  4  operation code, encoded in the shared package.
REQ-008 SHALL have port i_EX_aluSrc  input  1  1 selects i_EX_imm as operand B, 0 selects i_EX_rd2.
REQ-009 SHALL have ports i_EX_rd1, i_EX_rd2, i_EX_imm  input  32 each  operand A, register operand B / store data, and sign-extended immediate.
REQ-010 SHALL have ports o_EX_regWe, o_EX_dMemWe  output  1 each  registered controls to MEM.
REQ-011 SHALL have port o_EX_WRA  output  5  registered destination address.
REQ-012 SHALL have ports o_EX_aluOut, o_EX_WMA, o_EX_rd2  output  32 each  registered result, memory address, and store data.
REQ-013 SHALL have port o_EX_stall  output  1  upstream must hold its inputs while this is 1.

Function
REQ-014 SHALL support these ops: ADD, SUB, AND, OR, XOR, SLT (signed), SLL, SRL (shift amount = B[4:0]), MULT (signed), MFHI, MFLO.
REQ-015 SHALL use modulo-2^32 arithmetic for ADD/SUB, with no overflow trap.
REQ-016 SHALL, for a valid non-MULT instruction in IDLE, register its result into o_EX_aluOut after 1 cycle, with o_EX_WMA equal to the same result.
REQ-017 SHALL pass o_EX_rd2 through unchanged from i_EX_rd2, regardless of aluSrc.
REQ-018 SHALL force o_EX_regWe to 0 whenever i_EX_WRA is 0.
REQ-019 SHALL have an FSM with states IDLE, BUSY and FINISH.
REQ-020 SHALL, in IDLE on a valid MULT: latch |A| and |B| and sign = A[31]^B[31], clear the iteration counter, and go to BUSY.
REQ-021 SHALL, in BUSY, perform one shift-add iteration per cycle and go to FINISH after MUL_ITER iterations.
REQ-022 SHALL, in FINISH, negate the 64-bit product if sign=1, write HI=[63:32] and LO=[31:0], and return to IDLE.
REQ-023 SHALL drive o_EX_stall = (state==BUSY || state==FINISH), i.e. 1 for exactly MUL_ITER+1 cycles after MULT acceptance.
REQ-024 SHALL ignore all i_EX_* inputs while stalled.
REQ-025 SHALL emit a bubble (regWe=0, dMemWe=0, WRA=0) in each output cycle following the MULT acceptance cycle and every stall cycle.
REQ-026 SHALL also emit a bubble when i_EX_valid=0.
REQ-027 SHALL make MFHI/MFLO return HI/LO as updated by the most recent completed MULT; an MFHI/MFLO held behind a MULT stall reads the new values.
REQ-028 SHALL treat MULT with an operand equal to 0x80000000 correctly, its magnitude being held in 33 bits.

Reset
REQ-029 SHALL, on rstn low, immediately clear all outputs to 0, set o_EX_stall to 0, set state to IDLE, and clear HI, LO, counter and operand registers to 0.
REQ-030 SHALL discard an in-flight MULT if reset occurs during BUSY or FINISH, with HI/LO remaining 0.
REQ-031 SHALL accept a new instruction on the first rising edge after rstn deasserts.

Structure
REQ-032 SHALL take the aluOp encodings, FSM state encodings and MUL_ITER default from a shared package used by decode and EX.
REQ-033 SHALL place the iterative multiplier, including the FSM, counter and sign handling, in sub-module mul_unit, with start/busy/done handshake and a 64-bit product output.

Verification
REQ-034 SHALL cover: ADD rd1=5, rd2=7, WRA=3 -> next cycle aluOut=12, regWe=1, WRA=3.
REQ-035 SHALL cover: SLT rd1=0xFFFFFFFF, rd2=1 -> aluOut=1; SRL rd1=0x80000000, B=31 -> aluOut=1.
REQ-036 SHALL cover: MULT 7 by 0xFFFFFFFD, then MFLO, then MFHI -> stall=1 for 33 cycles, bubbles on MEM, then aluOut 0xFFFFFFEB followed by aluOut 0xFFFFFFFF.
REQ-037 SHALL cover: store with dMemWe=1, aluSrc=1, rd1=0x100, imm=8, rd2=0xABCD -> WMA=0x108, o_EX_rd2=0xABCD, dMemWe=1.
REQ-038 SHALL cover: ADD with WRA=0 -> o_EX_regWe=0.
REQ-039 SHALL cover: rstn low on the 10th BUSY cycle -> stall=0 immediately, then MFHI -> aluOut=0.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: ALU op codes, multiplier FSM states and MUL_ITER default shared by decode and EX.
package ex_stage_pkg;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLL, OP_SRL, OP_MULT, OP_MFHI, OP_MFLO
    } alu_op_e;
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FINISH} mul_state_e;
    localparam int MUL_ITER_DEF = 32;
endpackage

// File: rtl/ex_stage_mul_unit.sv
// mul_unit: iterative signed shift-add multiplier, one partial product per cycle.
// Ports: start (accepted only when idle), a/b operands, busy (BUSY or FINISH),
// done (FINISH cycle, product valid), product (64-bit signed result).
module mul_unit
    import ex_stage_pkg::*;
#(
    parameter int MUL_ITER = MUL_ITER_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] product
);
    localparam int CW = $clog2(MUL_ITER + 1);
    localparam logic [CW-1:0] LAST = CW'(MUL_ITER - 1);
    mul_state_e state, state_nx;
    logic [CW-1:0] cnt;
    logic [63:0] acc, mcand;
    logic [32:0] mplier, a_mag, b_mag;
    logic sign;
    // 33-bit magnitudes so that |0x80000000| = 2^31 is represented exactly
    assign a_mag = a[31] ? -{1'b1, a} : {1'b0, a};
    assign b_mag = b[31] ? -{1'b1, b} : {1'b0, b};
    assign product = sign ? -acc : acc;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nx;
    end
    always_comb begin
        state_nx = (state == S_IDLE && start)        ? S_BUSY   :
                   (state == S_BUSY && cnt == LAST)  ? S_FINISH :
                   (state == S_FINISH)               ? S_IDLE   : state;
        busy     = state != S_IDLE;
        done     = state == S_FINISH;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            {acc, mcand, mplier, sign, cnt} <= '0;
        end else if (state == S_IDLE && start) begin
            acc    <= '0;
            mcand  <= {31'b0, a_mag};
            mplier <= b_mag;
            sign   <= a[31] ^ b[31];
            cnt    <= '0;
        end else if (state == S_BUSY) begin
            acc    <= acc + (mplier[0] ? mcand : 64'd0);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage -- single-cycle ALU, HI/LO registers and a stalling iterative MULT.
// Inputs: i_EX_valid, decode controls (regWe, dMemWe, WRA, aluOp, aluSrc), operands rd1/rd2/imm.
// Outputs: registered MEM controls, aluOut, WMA (= aluOut), store data rd2, and o_EX_stall.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int MUL_ITER = MUL_ITER_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_EX_valid,
    input  logic        i_EX_regWe,
    input  logic        i_EX_dMemWe,
    input  logic [4:0]  i_EX_WRA,
    input  logic [3:0]  i_EX_aluOp,
    input  logic        i_EX_aluSrc,
    input  logic [31:0] i_EX_rd1,
    input  logic [31:0] i_EX_rd2,
    input  logic [31:0] i_EX_imm,
    output logic        o_EX_regWe,
    output logic        o_EX_dMemWe,
    output logic [4:0]  o_EX_WRA,
    output logic [31:0] o_EX_aluOut,
    output logic [31:0] o_EX_WMA,
    output logic [31:0] o_EX_rd2,
    output logic        o_EX_stall
);
    alu_op_e op;
    logic [31:0] opb, res, hi, lo;
    logic [63:0] product;
    logic busy, done, take, start;
    assign op    = alu_op_e'(i_EX_aluOp);
    assign opb   = i_EX_aluSrc ? i_EX_imm : i_EX_rd2;
    assign start = i_EX_valid && !busy && op == OP_MULT;
    // MULT itself and everything arriving while stalled leave a bubble
    assign take  = i_EX_valid && !busy && op != OP_MULT;
    assign o_EX_stall = busy;
    mul_unit #(.MUL_ITER(MUL_ITER)) u_mul (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .a       (i_EX_rd1),
        .b       (opb),
        .busy    (busy),
        .done    (done),
        .product (product)
    );
    always_comb begin
        res = '0;
        case (op)
            OP_ADD:  res = i_EX_rd1 + opb;
            OP_SUB:  res = i_EX_rd1 - opb;
            OP_AND:  res = i_EX_rd1 & opb;
            OP_OR:   res = i_EX_rd1 | opb;
            OP_XOR:  res = i_EX_rd1 ^ opb;
            OP_SLT:  res = {31'b0, $signed(i_EX_rd1) < $signed(opb)};
            OP_SLL:  res = i_EX_rd1 << opb[4:0];
            OP_SRL:  res = i_EX_rd1 >> opb[4:0];
            OP_MFHI: res = hi;
            OP_MFLO: res = lo;
            default: res = '0;
        endcase
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)     {hi, lo} <= '0;
        else if (done) {hi, lo} <= product;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            {o_EX_regWe, o_EX_dMemWe, o_EX_WRA, o_EX_aluOut, o_EX_WMA, o_EX_rd2} <= '0;
        end else begin
            o_EX_regWe  <= take && i_EX_regWe && (i_EX_WRA != 5'd0);
            o_EX_dMemWe <= take && i_EX_dMemWe;
            o_EX_WRA    <= take ? i_EX_WRA : 5'd0;
            o_EX_aluOut <= take ? res : 32'd0;
            o_EX_WMA    <= take ? res : 32'd0;
            o_EX_rd2    <= take ? i_EX_rd2 : 32'd0;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vector table, MULT stall sequences, mid-MULT reset, and random ops vs. a reference model.
module tb_ex_stage;
    import ex_stage_pkg::*;
    logic        clk = 0, rstn = 0;
    logic        valid = 0, regwe = 0, dwe = 0, src = 0;
    logic [4:0]  wra = 0;
    logic [3:0]  aluop = 0;
    logic [31:0] rd1 = 0, rd2 = 0, imm = 0;
    logic        o_regwe, o_dwe, o_stall;
    logic [4:0]  o_wra;
    logic [31:0] o_out, o_wma, o_rd2;
    logic [31:0] m_hi = 0, m_lo = 0;
    int nvec = 0, nerr = 0;

    ex_stage dut (
        .clk(clk), .rstn(rstn), .i_EX_valid(valid), .i_EX_regWe(regwe), .i_EX_dMemWe(dwe),
        .i_EX_WRA(wra), .i_EX_aluOp(aluop), .i_EX_aluSrc(src), .i_EX_rd1(rd1), .i_EX_rd2(rd2),
        .i_EX_imm(imm), .o_EX_regWe(o_regwe), .o_EX_dMemWe(o_dwe), .o_EX_WRA(o_wra),
        .o_EX_aluOut(o_out), .o_EX_WMA(o_wma), .o_EX_rd2(o_rd2), .o_EX_stall(o_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v, re, de, s;
        logic [3:0]  op;
        logic [4:0]  wra;
        logic [31:0] a, b, i;
        logic [31:0] e_out, e_rd2;
        logic        e_re, e_de;
        logic [4:0]  e_wra;
    } vec_t;
    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic s, input logic re, input logic de,
                         input logic [4:0] w, input logic [31:0] a, input logic [31:0] b, input logic [31:0] i);
        valid = v; aluop = op; src = s; regwe = re; dwe = de; wra = w; rd1 = a; rd2 = b; imm = i;
    endtask

    task automatic chk_out(input string tag, input logic data, input logic e_re, input logic e_de,
                           input logic [4:0] e_wra, input logic [31:0] e_out, input logic [31:0] e_rd2);
        check({tag, ".regWe"}, 32'(o_regwe), 32'(e_re));
        check({tag, ".dMemWe"}, 32'(o_dwe), 32'(e_de));
        check({tag, ".WRA"}, 32'(o_wra), 32'(e_wra));
        if (data) begin
            check({tag, ".aluOut"}, o_out, e_out);
            check({tag, ".WMA"}, o_wma, e_out);
            check({tag, ".rd2"}, o_rd2, e_rd2);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLT:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            OP_SLL:  return a * (32'd1 << sh);
            OP_SRL:  return a / (32'd1 << sh);
            OP_MFHI: return m_hi;
            OP_MFLO: return m_lo;
            default: return 32'd0;
        endcase
    endfunction

    // MULT followed by a held MFLO, then MFHI; checks stall length and bubbles
    task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int n;
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        drive(1, OP_MULT, 0, 1, 1, 5'd5, a, b, 0);
        step();
        drive(1, OP_MFLO, 0, 1, 0, 5'd6, 32'hDEAD, 32'hBEEF, 0);
        n = 0;
        while (o_stall === 1'b1 && n < 100) begin
            chk_out({tag, ".bubble"}, 0, 0, 0, 0, 0, 0);
            step();
            n++;
        end
        check({tag, ".stall_cycles"}, 32'(n), 32'd33);
        chk_out({tag, ".last_bubble"}, 0, 0, 0, 0, 0, 0);
        m_hi = p[63:32];
        m_lo = p[31:0];
        step();
        chk_out({tag, ".mflo"}, 1, 1, 0, 5'd6, m_lo, 32'hBEEF);
        drive(1, OP_MFHI, 0, 1, 0, 5'd7, 0, 0, 0);
        step();
        chk_out({tag, ".mfhi"}, 1, 1, 0, 5'd7, m_hi, 0);
        drive(0, OP_ADD, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        tbl[0]  = '{1, 1, 0, 0, OP_ADD,  5'd3, 32'd5, 32'd7, 0,          32'd12,       32'd7,      1, 0, 5'd3};
        tbl[1]  = '{1, 1, 0, 0, OP_SLT,  5'd4, 32'hFFFFFFFF, 32'd1, 0,   32'd1,        32'd1,      1, 0, 5'd4};
        tbl[2]  = '{1, 1, 0, 1, OP_SRL,  5'd5, 32'h80000000, 0, 32'd31, 32'd1,        0,          1, 0, 5'd5};
        tbl[3]  = '{1, 0, 1, 1, OP_ADD,  5'd0, 32'h100, 32'hABCD, 32'd8, 32'h108,      32'hABCD,   0, 1, 5'd0};
        tbl[4]  = '{1, 1, 0, 0, OP_ADD,  5'd0, 32'd5, 32'd7, 0,          32'd12,       32'd7,      0, 0, 5'd0};
        tbl[5]  = '{0, 1, 1, 0, OP_ADD,  5'd7, 32'd1, 32'd2, 0,          0,            0,          0, 0, 5'd0};
        tbl[6]  = '{1, 1, 0, 0, OP_SUB,  5'd8, 32'd3, 32'd5, 0,          32'hFFFFFFFE, 32'd5,      1, 0, 5'd8};
        tbl[7]  = '{1, 1, 0, 0, OP_XOR,  5'd9, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'h0FF00FF0, 32'hFF00FF00, 1, 0, 5'd9};
        tbl[8]  = '{1, 1, 0, 1, OP_SLL,  5'd10, 32'd1, 32'd99, 32'h24,   32'h10,       32'd99,     1, 0, 5'd10};
        tbl[9]  = '{1, 1, 0, 0, OP_AND,  5'd11, 32'hF0F0, 32'hFF00, 0,   32'hF000,     32'hFF00,   1, 0, 5'd11};
        tbl[10] = '{1, 1, 0, 0, OP_SLT,  5'd12, 32'd1, 32'hFFFFFFFF, 0,  32'd0,        32'hFFFFFFFF, 1, 0, 5'd12};
        tbl[11] = '{1, 1, 0, 0, OP_MFHI, 5'd13, 0, 0, 0,                 32'd0,        0,          1, 0, 5'd13};
        #3;
        chk_out("reset", 1, 0, 0, 0, 0, 0);
        check("reset.stall", 32'(o_stall), 0);
        #9 rstn = 1;
        for (int k = 0; k < 12; k++) begin
            drive(tbl[k].v, tbl[k].op, tbl[k].s, tbl[k].re, tbl[k].de, tbl[k].wra, tbl[k].a, tbl[k].b, tbl[k].i);
            step();
            chk_out($sformatf("vec%0d", k), tbl[k].v, tbl[k].e_re, tbl[k].e_de, tbl[k].e_wra, tbl[k].e_out, tbl[k].e_rd2);
        end
        run_mult("mult_7x-3", 32'd7, 32'hFFFFFFFD);
        check("mult_7x-3.lo_const", m_lo, 32'hFFFFFFEB);
        check("mult_7x-3.hi_const", m_hi, 32'hFFFFFFFF);
        run_mult("mult_min_min", 32'h80000000, 32'h80000000);
        run_mult("mult_min_one", 32'h80000000, 32'd1);
        run_mult("mult_min_neg1", 32'hFFFFFFFF, 32'h80000000);
        // reset on the 10th BUSY cycle discards the MULT and clears HI/LO
        drive(1, OP_MULT, 0, 0, 0, 0, 32'd9, 32'd9, 0);
        step();
        drive(1, OP_MFHI, 0, 1, 0, 5'd4, 0, 0, 0);
        for (int k = 0; k < 9; k++) step();
        check("rst_mid.stall_before", 32'(o_stall), 1);
        rstn = 0;
        m_hi = 0;
        m_lo = 0;
        #1;
        check("rst_mid.stall", 32'(o_stall), 0);
        chk_out("rst_mid.out", 1, 0, 0, 0, 0, 0);
        #2 rstn = 1;
        step();
        chk_out("rst_mid.mfhi", 1, 1, 0, 5'd4, 0, 0);
        check("rst_mid.no_stall", 32'(o_stall), 0);
        drive(1, OP_MFLO, 0, 1, 0, 5'd5, 0, 0, 0);
        step();
        chk_out("rst_mid.mflo", 1, 1, 0, 5'd5, 0, 0);
        for (int k = 0; k < 150; k++) begin
            logic [3:0] op;
            logic v, s, re, de;
            logic [4:0] w;
            logic [31:0] a, b, i, e;
            op = 4'($urandom_range(0, 10));
            a = $urandom; b = $urandom; i = $urandom;
            if (op == OP_MULT) begin
                case ($urandom_range(0, 3))
                    0: a = 32'h80000000;
                    1: b = 0;
                    default: ;
                endcase
                run_mult($sformatf("rnd%0d.mult", k), a, b);
            end else begin
                v = $urandom_range(0, 7) != 0;
                s = 1'($urandom);
                re = 1'($urandom);
                de = 1'($urandom);
                w = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
                e = ref_alu(op, a, s ? i : b);
                drive(v, op, s, re, de, w, a, b, i);
                step();
                chk_out($sformatf("rnd%0d.op%0d", k, op), v, v && re && w != 0, v && de, v ? w : 5'd0, e, b);
            end
        end
        drive(0, OP_ADD, 0, 0, 0, 0, 0, 0, 0);
        step();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
